// File: rtl/nios2_cpu_div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nios2_cpu_div_pkg                                                        |
// | Shared types, default sizes and sign helpers for the Nios II divider.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package nios2_cpu_div_pkg;

    localparam int c_div_width = 32;
    localparam int c_div_cnt_w = 6;
    // Widest operand the sign helpers handle; callers zero-extend and truncate.
    localparam int c_max_w     = 64;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    // Low bits of a two's-complement negation depend only on low bits of the input.
    function automatic logic [c_max_w-1:0] div_negate(input logic [c_max_w-1:0] v,
                                                      input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [c_max_w-1:0] div_abs(input logic [c_max_w-1:0] v,
                                                   input logic msb,
                                                   input logic is_signed);
        return div_negate(v, is_signed & msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nios2_cpu_div_step.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nios2_cpu_div_step                                                       |
// | One combinational restoring-division step: (P, A_msb, D) -> (P', q).     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module nios2_cpu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   p,
    input  logic             a_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   p_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;

    // P < D holds between steps, so the shifted value stays below 2**(WIDTH+1)
    // and the top bit of the difference is a valid borrow.
    assign w_shift = {p, a_msb};
    assign w_diff  = w_shift - {2'b00, d};
    assign q_bit   = ~w_diff[WIDTH+1];
    assign p_next  = q_bit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

endmodule
`default_nettype wire

// File: rtl/nios2_cpu_div_cell.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nios2_cpu_div_cell                                                       |
// | Multicycle radix-2 restoring signed/unsigned divider, abortable.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module nios2_cpu_div_cell
    import nios2_cpu_div_pkg::*;
#(
    parameter int WIDTH = c_div_width,
    parameter int CNT_W = c_div_cnt_w
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] E_src1,
    input  logic [WIDTH-1:0] E_src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_t       r_state;
    div_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_src1;
    logic [WIDTH-1:0] r_src2;
    logic             r_signed;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH:0]   r_p;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dz;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_p_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && start && !abort;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    assign w_abs1  = WIDTH'(div_abs(c_max_w'(r_src1), r_src1[WIDTH-1], r_signed));
    assign w_abs2  = WIDTH'(div_abs(c_max_w'(r_src2), r_src2[WIDTH-1], r_signed));
    assign w_q_fix = WIDTH'(div_negate(c_max_w'(r_a), r_q_neg));
    assign w_r_fix = WIDTH'(div_negate(c_max_w'(r_p[WIDTH-1:0]), r_r_neg));

    nios2_cpu_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .p      (r_p),
        .a_msb  (r_a[WIDTH-1]),
        .d      (r_d),
        .p_next (w_p_next),
        .q_bit  (w_q_bit)
    );

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: w_next = start ? PREP : IDLE;
                PREP:       w_next = ITER;
                ITER:       w_next = w_last ? FIX : ITER;
                FIX:        w_next = DONE;
                default:    w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_signed <= 1'b0;
            r_a      <= '0;
            r_d      <= '0;
            r_p      <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_dz     <= 1'b0;
            r_quot   <= '0;
            r_rem    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_src1   <= E_src1;
                r_src2   <= E_src2;
                r_signed <= div_signed;
            end
            case (r_state)
                PREP: begin
                    r_a     <= w_abs1;
                    r_d     <= w_abs2;
                    r_p     <= '0;
                    r_cnt   <= '0;
                    r_q_neg <= r_signed & (r_src1[WIDTH-1] ^ r_src2[WIDTH-1]);
                    r_r_neg <= r_signed & r_src1[WIDTH-1];
                    r_dz    <= (r_src2 == '0);
                end
                ITER: begin
                    r_p   <= w_p_next;
                    r_a   <= {r_a[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    // A flush landing on the fix-up edge must leave results untouched.
                    if (!abort) begin
                        r_quot <= r_dz ? '1 : w_q_fix;
                        r_rem  <= r_dz ? r_src1 : w_r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == ITER) || (r_state == FIX);
    assign done      = (r_state == DONE);
    assign quotient  = r_quot;
    assign remainder = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_nios2_cpu_div_cell.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nios2_cpu_div_cell                                                    |
// | Directed vector bench for the divider: results, latency, abort, reset.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_nios2_cpu_div_cell;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] E_src1 = '0;
    logic [31:0] E_src2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [31:0] eq;
        logic [31:0] er;
    } vec_t;

    vec_t vecs[11];

    nios2_cpu_div_cell #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .div_signed (div_signed),
        .E_src1     (E_src1),
        .E_src2     (E_src2),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            n_pass++;
    endtask

    // Called away from a clock edge; returns #1 after the edge that raised done.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input logic interfere, output int lat, output int bc);
        E_src1 = a;
        E_src2 = b;
        div_signed = sg;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        bc = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bc++;
            if (interfere && lat == 5) begin
                start = 1'b1;
                E_src1 = 32'd50;
                E_src2 = 32'd5;
                div_signed = 1'b0;
            end else if (interfere && lat == 6) begin
                start = 1'b0;
            end
            if (done) break;
        end
    endtask

    task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic sg, input logic interfere,
                            input logic [31:0] eq, input logic [31:0] er);
        int lat;
        int bc;
        launch(a, b, sg, interfere, lat, bc);
        chk({tag, " latency"}, lat, 32'd34);
        chk({tag, " busy_cycles"}, bc, 32'd33);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
    endtask

    initial begin
        int dcnt;

        vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2};
        vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[2]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1};
        vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0};
        vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000};
        vecs[5]  = '{32'h12345678, 32'd0,        1'b1, 32'hFFFFFFFF, 32'h12345678};
        vecs[6]  = '{32'h12345678, 32'd0,        1'b0, 32'hFFFFFFFF, 32'h12345678};
        vecs[7]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0};
        vecs[8]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE};
        vecs[9]  = '{32'hDEADBEEF, 32'h10,       1'b0, 32'h0DEADBEE, 32'hF};
        vecs[10] = '{32'h80000001, 32'd0,        1'b1, 32'hFFFFFFFF, 32'h80000001};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Every vector after the first is launched from the DONE cycle.
        for (int i = 0; i < 11; i++)
            check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sg, 1'b0,
                     vecs[i].eq, vecs[i].er);

        @(posedge clk);
        #1;
        chk("done one-cycle pulse", {31'd0, done}, 32'd0);
        chk("idle busy after done", {31'd0, busy}, 32'd0);

        // Abort during ITER with counter at 10; previous results (vec10) must hold.
        E_src1 = 32'd1000;
        E_src2 = 32'd3;
        div_signed = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort quotient held", quotient, 32'hFFFFFFFF);
        chk("abort remainder held", remainder, 32'h80000001);
        check_op("post-abort", 32'd1000, 32'd3, 1'b0, 1'b0, 32'd333, 32'd1);

        // abort and start together in IDLE: must not launch.
        @(posedge clk);
        #1;
        E_src1 = 32'd9;
        E_src2 = 32'd2;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
        chk("abort+start busy", {31'd0, busy}, 32'd0);
        dcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        chk("abort+start no done", dcnt, 32'd0);
        chk("abort+start quotient held", quotient, 32'd333);

        // start pulsed mid-operation with other operands must be ignored.
        check_op("start-while-busy", 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2);

        // Reset mid-ITER clears everything immediately.
        @(posedge clk);
        #1;
        E_src1 = 32'd1000;
        E_src2 = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset done", {31'd0, done}, 32'd0);
        chk("midreset quotient", quotient, 32'd0);
        chk("midreset remainder", remainder, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_op("post-reset", 32'hFFFFFF9C, 32'd7, 1'b1, 1'b0, 32'hFFFFFFF2, 32'hFFFFFFFE);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
